// File: rtl/twos_comp_decoder.sv
// twos_comp_decoder: bit-serial two's-complement to sign/magnitude converter,
// one bit per cycle LSB first, with a valid/ready handshake on each side.
module twos_comp_decoder #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, mag;
  logic [CW-1:0]    cnt;
  logic             sign, carry, b;
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = SHIFT;
    if (state == SHIFT && cnt == CW'(WIDTH - 1)) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  // Negation as invert-and-increment: the carry seeds the +1 only for negatives.
  assign b         = shreg[0] ^ sign;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign out_sign  = sign;
  assign out_mag   = mag;
  assign out_zero  = ~|mag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      mag   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      carry <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        shreg <= in_data;
        sign  <= in_data[WIDTH-1];
        carry <= in_data[WIDTH-1];
        cnt   <= '0;
      end else if (state == SHIFT) begin
        mag   <= {b ^ carry, mag[WIDTH-1:1]};
        carry <= b & carry;
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_twos_comp_decoder.sv
// tb_twos_comp_decoder: randomized and directed checks of twos_comp_decoder
// against an arithmetic reference (sign and absolute value of the operand).
module tb_twos_comp_decoder;
  localparam int W = 6;
  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, out_sign, out_zero;
  logic [W-1:0] out_mag;
  int tests = 0, fails = 0;

  twos_comp_decoder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int signed_val(input logic [W-1:0] d);
    return d[W-1] ? int'(d) - (1 << W) : int'(d);
  endfunction

  function automatic int abs_val(input logic [W-1:0] d);
    int v = signed_val(d);
    return v < 0 ? -v : v;
  endfunction

  // Present a word in IDLE, then wait for DONE with out_ready low; junk is
  // driven on in_valid/in_data/out_ready while the conversion is busy.
  task automatic send(input logic [W-1:0] d, output int lat);
    in_valid = 1;
    in_data  = d;
    out_ready = 0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 0;
    out_ready = 0;
  endtask

  task automatic release_out();
    out_ready = 1;
    in_valid = 0;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if ({out_sign, out_mag, out_zero} !== {1'b0, {W{1'b0}}, 1'b1})
      begin fails++; $display("FAIL reset_outputs got sign=%b mag=%b zero=%b want 0 0 1", out_sign, out_mag, out_zero); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] din[4]  = '{6'b101110, 6'b000000, 6'b100000, 6'b011111};
    logic [W-1:0] emag[4] = '{6'b010010, 6'b000000, 6'b100000, 6'b011111};
    logic         esgn[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(din[i], lat);
      tests++; if (lat != W) begin fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, W); end
      tests++; if (out_sign !== esgn[i]) begin fails++; $display("FAIL vec%0d_sign got %b want %b", i, out_sign, esgn[i]); end
      tests++; if (out_mag !== emag[i]) begin fails++; $display("FAIL vec%0d_mag got %b want %b", i, out_mag, emag[i]); end
      tests++; if (out_zero !== (emag[i] == 0)) begin fails++; $display("FAIL vec%0d_zero got %b want %b", i, out_zero, emag[i] == 0); end
      release_out();
      tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL vec%0d_return got valid=%b ready=%b want 0 1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(6'b111111, lat);
    for (int c = 0; c < 10; c++) begin
      tests++;
      if ({out_valid, in_ready, out_sign, out_mag, out_zero} !== {1'b1, 1'b0, 1'b1, 6'b000001, 1'b0}) begin
        fails++;
        $display("FAIL hold_c%0d got valid=%b ready=%b sign=%b mag=%b zero=%b want 1 0 1 000001 0",
                 c, out_valid, in_ready, out_sign, out_mag, out_zero);
      end
      in_valid = 1;
      in_data  = W'($urandom);
      @(posedge clk); #1;
    end
    release_out();
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL hold_release got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen = 0;
    in_valid = 1;
    in_data  = 6'b110110;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    tests++;
    if ({in_ready, out_valid, out_sign, out_mag, out_zero} !== {1'b1, 1'b0, 1'b0, 6'b0, 1'b1}) begin
      fails++;
      $display("FAIL midreset_outputs got ready=%b valid=%b sign=%b mag=%b zero=%b want 1 0 0 000000 1",
               in_ready, out_valid, out_sign, out_mag, out_zero);
    end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    tests++; if (seen) begin fails++; $display("FAIL midreset_no_result got out_valid=1 want 0"); end
    rst_n = 0;
    #3;
    rst_n = 1;
    send(6'b001001, lat);
    tests++; if (lat != W) begin fails++; $display("FAIL post_reset_latency got %0d want %0d", lat, W); end
    tests++; if ({out_sign, out_mag} !== {1'b0, 6'b001001}) begin fails++; $display("FAIL post_reset_mag got sign=%b mag=%b want 0 001001", out_sign, out_mag); end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] d;
    for (int i = 0; i < 25; i++) begin
      d = W'($urandom);
      send(d, lat);
      tests++;
      if (lat != W || out_sign !== (signed_val(d) < 0) || int'(out_mag) != abs_val(d) || out_zero !== (abs_val(d) == 0)) begin
        fails++;
        $display("FAIL rand%0d in=%b got lat=%0d sign=%b mag=%0d zero=%b want lat=%0d sign=%b mag=%0d zero=%b",
                 i, d, lat, out_sign, out_mag, out_zero, W, signed_val(d) < 0, abs_val(d), abs_val(d) == 0);
      end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    logic [W-1:0] e;
    int last = -1, results = 0;
    in_valid = 1;
    out_ready = 1;
    for (int c = 0; c < 80; c++) begin
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected result at cycle %0d got mag=%0d want none", c, out_mag);
        end else begin
          e = q.pop_front();
          if (out_sign !== (signed_val(e) < 0) || int'(out_mag) != abs_val(e)) begin
            fails++;
            $display("FAIL b2b_result in=%b got sign=%b mag=%0d want sign=%b mag=%0d",
                     e, out_sign, out_mag, signed_val(e) < 0, abs_val(e));
          end
        end
        if (last >= 0) begin
          tests++;
          if (c - last != W + 2) begin fails++; $display("FAIL b2b_spacing got %0d want %0d", c - last, W + 2); end
        end
        last = c;
        results++;
      end
      in_data = W'($urandom);
      if (in_ready) q.push_back(in_data);
      @(posedge clk); #1;
    end
    tests++; if (results < 8) begin fails++; $display("FAIL b2b_count got %0d want >=8", results); end
    in_valid = 0;
    repeat (W + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
